spu_sm_ctrl: RTL

Sequencer and configuration holder for the softmax exp-approximation LUT unit in the SPU softmax path. It drives the 3-bit `sm_state` bus through MAX → EU_STAGE_A → RECI → EU_STAGE_B for one row, and gates input beats with a valid/ready handshake. It drains the 3-stage exp pipeline and flags when exp outputs are valid. It also owns the 128-bit LUT table and the output scale shift, both written through a simple config port.

---
 rtl/spu_sm_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spu_sm_ctrl.sv
// rtl/spu_sm_ctrl.sv - softmax exp-LUT sequencer (MAX/EU_A/RECI/EU_B) and LUT/shift config holder
// Optional busy-cycle counter built when SPU_SM_CTRL_PERF_CNT_EN is defined.
module spu_sm_ctrl #(
    parameter int ROW_LEN_W   = 8,
    parameter int RECI_CYCLES = 10
) (
    input  logic                 core_clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [15:0]          cfg_wdata,
    input  logic                 cfg_shift_we,
    input  logic [4:0]           cfg_shift,
    output logic                 cfg_err,
    input  logic                 start,
    input  logic [ROW_LEN_W-1:0] row_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 exp_valid,
    output logic [2:0]           sm_state,
    output logic [127:0]         sm_lut_config,
    output logic [4:0]           output_scale_shift,
    output logic [15:0]          perf_cycles
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        EU_A = 3'b001,
        RECI = 3'b011,
        EU_B = 3'b100,
        MAX  = 3'b101
    } state_t;

    localparam int RCW = $clog2(RECI_CYCLES + 1);

    state_t               state, state_nx;
    logic [ROW_LEN_W-1:0] n_q, beat_cnt;
    logic                 drain_cnt;
    logic [RCW-1:0]       reci_cnt;
    logic [2:0]           exp_pipe;
    logic                 fire, last_beat, start_ok, abort_ok, pass_adv, row_end;

    assign sm_state  = state;
    assign busy      = (state != IDLE);
    assign exp_valid = exp_pipe[2];
    assign fire      = in_valid & in_ready;
    assign last_beat = fire && (beat_cnt == n_q - 1'b1);
    assign start_ok  = (state == IDLE) && start && (row_len != '0);
    assign abort_ok  = abort && (state != IDLE);

    always_comb begin
        in_ready = ((state == MAX) || (state == EU_A) || (state == EU_B)) && (beat_cnt != n_q);
    end

    always_comb begin
        state_nx = state;
        pass_adv = 1'b0;
        row_end  = 1'b0;
        if (abort_ok) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start_ok) state_nx = MAX;
                MAX: if (last_beat) begin
                    state_nx = EU_A;
                    pass_adv = 1'b1;
                end
                // two drain cycles after the last beat let the exp pipe empty
                EU_A: if ((beat_cnt == n_q) && drain_cnt) begin
                    state_nx = RECI;
                    pass_adv = 1'b1;
                end
                RECI: if (reci_cnt == RCW'(RECI_CYCLES - 1)) begin
                    state_nx = EU_B;
                    pass_adv = 1'b1;
                end
                EU_B: if (last_beat) begin
                    state_nx = IDLE;
                    pass_adv = 1'b1;
                    row_end  = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            n_q                <= '0;
            beat_cnt           <= '0;
            drain_cnt          <= 1'b0;
            reci_cnt           <= '0;
            exp_pipe           <= '0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
            sm_lut_config      <= '0;
            output_scale_shift <= '0;
        end else begin
            state   <= state_nx;
            done    <= row_end;
            cfg_err <= (cfg_we | cfg_shift_we) && (state != IDLE);
            if (start_ok)
                n_q <= row_len;
            if (abort_ok || pass_adv || start_ok) begin
                beat_cnt  <= '0;
                drain_cnt <= 1'b0;
                reci_cnt  <= '0;
            end else begin
                if (fire)
                    beat_cnt <= beat_cnt + 1'b1;
                if ((state == EU_A) && (beat_cnt == n_q))
                    drain_cnt <= 1'b1;
                if (state == RECI)
                    reci_cnt <= reci_cnt + 1'b1;
            end
            exp_pipe <= abort_ok ? 3'b000 : {exp_pipe[1:0], fire && (state == EU_A)};
            if (state == IDLE) begin
                if (cfg_we)
                    sm_lut_config[{cfg_addr, 4'b0000} +: 16] <= cfg_wdata;
                if (cfg_shift_we)
                    output_scale_shift <= cfg_shift;
            end
        end
    end

`ifdef SPU_SM_CTRL_PERF_CNT_EN
    logic [15:0] busy_cnt;

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            busy_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (start_ok)
                busy_cnt <= '0;
            else if (busy && (busy_cnt != 16'hFFFF))
                busy_cnt <= busy_cnt + 16'd1;
            if (done)
                perf_cycles <= busy_cnt;
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule
